// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential signed divider: default width,
// iteration counter width and FSM state encodings.
package div_seq_32_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;   // covers 0..32

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_32_step.sv
// One restoring-division trial subtract: diff = rem_in - divisor, computed
// as rem_in + ~divisor + 1 through a ripple of full-adder cells.
// ge is the final carry out, i.e. rem_in >= divisor (unsigned).
module div_seq_32_step #(
    parameter int W = 33
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] diff,
    output logic         ge
);

    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_fa
        logic b_inv;
        assign b_inv      = ~divisor[i];
        assign diff[i]    = rem_in[i] ^ b_inv ^ carry[i];
        assign carry[i+1] = (rem_in[i] & b_inv) | (rem_in[i] & carry[i]) | (b_inv & carry[i]);
    end

    assign ge = carry[W];

endmodule

// File: rtl/div_seq_32.sv
// Multi-cycle signed divider, one quotient bit per clock (restoring).
// Operands are converted to magnitudes in a WIDTH+1 datapath so that -2^(W-1)
// keeps its magnitude; the sign is re-applied when the last bit is produced.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for ctrl_DIV; outputs hold last result
// S_RUN  | WIDTH shift/trial-subtract iterations
// S_DONE | data_resultRDY high for this single cycle
module div_seq_32
    import div_seq_32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t               state, state_nxt;
    logic [DIV_CNT_W-1:0] count;
    logic [WIDTH:0]       rem;
    logic [WIDTH:0]       divisor;
    logic [WIDTH-1:0]     quo;
    logic                 sign_q;
    logic                 dz;
    logic [WIDTH-1:0]     result_q;
    logic                 exc_q;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       rem_sh, diff;
    logic                 ge;
    logic [WIDTH-1:0]     quo_nxt;
    logic                 last_iter;

    // Two's-complement magnitudes; 0x80..0 maps onto itself, which is correct unsigned.
    assign mag_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

    assign rem_sh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign quo_nxt   = {quo[WIDTH-2:0], ge};
    assign last_iter = (state == S_RUN) && (count == DIV_CNT_W'(WIDTH - 1));

    div_seq_32_step #(.W(WIDTH + 1)) u_step (
        .rem_in  (rem_sh),
        .divisor (divisor),
        .diff    (diff),
        .ge      (ge)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and ready pulse; a start in any state restarts the operation.
    always_comb begin
        state_nxt      = state;
        data_resultRDY = 1'b0;
        case (state)
            S_IDLE: if (ctrl_DIV) state_nxt = S_RUN;
            S_RUN: begin
                if (ctrl_DIV)       state_nxt = S_RUN;
                else if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                data_resultRDY = 1'b1;
                state_nxt      = ctrl_DIV ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= '0;
            rem      <= '0;
            divisor  <= '0;
            quo      <= '0;
            sign_q   <= 1'b0;
            dz       <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (ctrl_DIV) begin
            count    <= '0;
            rem      <= '0;
            divisor  <= {1'b0, mag_b};
            quo      <= mag_a;
            sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz       <= (data_operandB == '0);
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (state == S_RUN) begin
            rem   <= ge ? diff : rem_sh;
            quo   <= quo_nxt;
            count <= count + DIV_CNT_W'(1);
            if (last_iter) begin
                // Divide-by-zero still runs the full latency; its quotient is discarded.
                result_q <= dz ? '0 : (sign_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt);
                exc_q    <= dz;
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;

endmodule

// File: tb/tb_div_seq_32.sv
module tb_div_seq_32;

    logic        clk;
    logic        rst;
    logic        ctrl;
    logic [31:0] op_a, op_b;
    logic [31:0] res;
    logic        exc;
    logic        rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // {exception, quotient}
    logic [32:0] sb[$];

    localparam int LATENCY = 32;   // posedges after the start edge until RDY is seen

    div_seq_32 dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_DIV       (ctrl),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (res),
        .data_exception (exc),
        .data_resultRDY (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000};
        q = 32'($signed(a) / $signed(b));
        return {1'b0, q};
    endfunction

    // Pulse ctrl_DIV for one edge; returns at the falling edge after the start edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        @(negedge clk);
        op_a = a;
        op_b = b;
        ctrl = 1'b1;
        if (push) sb.push_back(ref_div(a, b));
        @(negedge clk);
        ctrl = 1'b0;
    endtask

    // Wait for RDY, check latency, compare against the scoreboard, then check hold.
    task automatic wait_rdy(input string name);
        int          n;
        logic [32:0] e;
        logic [31:0] held;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rdy) break;
        end
        e = (sb.size() > 0) ? sb.pop_front() : 33'h1_FFFF_FFFF;
        n_tests++;
        if (!rdy || n != LATENCY) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges (rdy=%b), expected %0d", name, n, rdy, LATENCY);
        end
        n_tests++;
        if (res !== e[31:0]) begin
            n_fail++;
            $display("FAIL %s result: got %h, expected %h", name, res, e[31:0]);
        end
        n_tests++;
        if (exc !== e[32]) begin
            n_fail++;
            $display("FAIL %s exception: got %b, expected %b", name, exc, e[32]);
        end
        held = res;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (rdy !== 1'b0 || res !== held || exc !== e[32]) begin
                n_fail++;
                $display("FAIL %s hold: rdy=%b res=%h exc=%b, expected rdy=0 res=%h exc=%b",
                         name, rdy, res, exc, held, e[32]);
            end
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input string name);
        start_op(a, b, 1'b1);
        wait_rdy(name);
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        ctrl = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (res !== 32'd0 || exc !== 1'b0 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: res=%h exc=%b rdy=%b, expected all 0", res, exc, rdy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        do_op(32'd100, 32'd7, "basic_100_7");
    endtask

    task automatic test_signs;
        do_op(32'hFFFF_FF9C, 32'd7,         "neg_pos");
        do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, "neg_neg");
        do_op(32'd7,         32'hFFFF_FF9C, "small_over_big");
    endtask

    task automatic test_div_zero;
        do_op(32'd123, 32'd0, "div_zero");
        // Next start must clear the held exception/result on its start edge.
        start_op(32'd20, 32'd4, 1'b1);
        n_tests++;
        if (exc !== 1'b0 || res !== 32'd0) begin
            n_fail++;
            $display("FAIL start_clear: res=%h exc=%b, expected 0/0", res, exc);
        end
        wait_rdy("after_div_zero");
    endtask

    task automatic test_overflow;
        do_op(32'h8000_0000, 32'hFFFF_FFFF, "ovf_min_neg1");
        do_op(32'h8000_0000, 32'd1,         "min_over_1");
    endtask

    task automatic test_abort;
        start_op(32'd50, 32'd5, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_tests++;
            if (rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_early_rdy: rdy=%b at cycle %0d, expected 0", rdy, k + 1);
            end
        end
        start_op(32'd81, 32'd9, 1'b1);
        wait_rdy("abort_restart");
    endtask

    task automatic test_reset_mid;
        int pulses;
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (res !== 32'd0 || exc !== 1'b0 || rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: res=%h exc=%b rdy=%b, expected all 0", res, exc, rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rdy: got %0d pulses, expected 0", pulses);
        end
        do_op(32'd9, 32'd3, "after_reset");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) b = 32'($urandom_range(1, 300));
            if (i % 4 == 1) b = -b;
            if (i % 5 == 2) a = 32'($urandom_range(0, 5000)) - 32'd2500;
            do_op(a, b, "random");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signs;
        test_div_zero;
        test_overflow;
        test_abort;
        test_reset_mid;
        test_random;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
